// File: rtl/vid_timing_pkg.sv
// Shared types and standard raster timings for the video timing generator.
package vid_timing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRun
  } state_e;

  // 1080p60 (148.5 MHz pixel clock)
  localparam int unsigned Hd1080HActive = 1920;
  localparam int unsigned Hd1080HFront  = 88;
  localparam int unsigned Hd1080HSync   = 44;
  localparam int unsigned Hd1080HBack   = 148;
  localparam int unsigned Hd1080VActive = 1080;
  localparam int unsigned Hd1080VFront  = 4;
  localparam int unsigned Hd1080VSync   = 5;
  localparam int unsigned Hd1080VBack   = 36;

  // 720p60 (74.25 MHz pixel clock)
  localparam int unsigned Hd720HActive = 1280;
  localparam int unsigned Hd720HFront  = 110;
  localparam int unsigned Hd720HSync   = 40;
  localparam int unsigned Hd720HBack   = 220;
  localparam int unsigned Hd720VActive = 720;
  localparam int unsigned Hd720VFront  = 5;
  localparam int unsigned Hd720VSync   = 5;
  localparam int unsigned Hd720VBack   = 20;

endpackage

// File: rtl/vid_axis_cnt.sv
// Wrap counter for one raster axis: counts 0..Count-1, parks at Count-1 when told to.
module vid_axis_cnt #(
  parameter int unsigned Count = 16,
  localparam int unsigned W = $clog2(Count)
) (
  input  logic         clk,
  input  logic         park_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_d_o,
  output logic         last_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] Last = W'(Count - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (park_i) begin
      cnt_d = Last;
    end else if (inc_i) begin
      cnt_d = (cnt_q == Last) ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;
  assign last_o  = (cnt_q == Last);
  assign wrap_o  = inc_i && (cnt_q == Last);

endmodule

// File: rtl/vid_timing_gen.sv
// Free-running raster counter with frame-boundary start/stop and optional frame lock
// to an external frame-sync pulse.
module vid_timing_gen
  import vid_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE      = Hd1080HActive,
  parameter int unsigned H_FRONT_PORCH = Hd1080HFront,
  parameter int unsigned H_SYNC_WIDTH  = Hd1080HSync,
  parameter int unsigned H_BACK_PORCH  = Hd1080HBack,
  parameter int unsigned V_ACTIVE      = Hd1080VActive,
  parameter int unsigned V_FRONT_PORCH = Hd1080VFront,
  parameter int unsigned V_SYNC_WIDTH  = Hd1080VSync,
  parameter int unsigned V_BACK_PORCH  = Hd1080VBack,
  parameter int unsigned SYNC_MODE     = 0,
  localparam int unsigned H_FRAME = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int unsigned V_FRAME = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int unsigned HW      = $clog2(H_FRAME),
  localparam int unsigned VW      = $clog2(V_FRAME)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ext_fsync,
  output logic [HW-1:0] out_hcnt,
  output logic [VW-1:0] out_vcnt,
  output logic          out_de,
  output logic          out_de_d1,
  output logic          out_line_start,
  output logic          out_frame_start,
  output logic          out_running,
  output logic          out_fsync_ovf
);

  localparam bit SyncOn = (SYNC_MODE != 0);

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic          de_q, de_d, de_d1_q;
  logic          line_q, line_d, frame_q, frame_d, ovf_q, ovf_d;
  logic          adv, consume, fsync_set, frame_end;
  logic [HW-1:0] h_cnt, h_cnt_d;
  logic [VW-1:0] v_cnt, v_cnt_d;
  logic          h_last, h_wrap, v_last, v_wrap;

  // Counters only ever stop at the park position, so entering RUN is a plain wrap to 0,0.
  vid_axis_cnt #(.Count(H_FRAME)) u_hcnt (
    .clk     (clk),
    .park_i  (rst | ~adv),
    .inc_i   (adv),
    .cnt_o   (h_cnt),
    .cnt_d_o (h_cnt_d),
    .last_o  (h_last),
    .wrap_o  (h_wrap)
  );

  vid_axis_cnt #(.Count(V_FRAME)) u_vcnt (
    .clk     (clk),
    .park_i  (rst | ~adv),
    .inc_i   (h_wrap),
    .cnt_o   (v_cnt),
    .cnt_d_o (v_cnt_d),
    .last_o  (v_last),
    .wrap_o  (v_wrap)
  );

  always_comb begin
    state_d   = state_q;
    consume   = 1'b0;
    frame_end = (state_q == StRun) && h_last && v_last;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          if (SyncOn && !pending_q) begin
            state_d = StWait;
          end else begin
            state_d = StRun;
            consume = 1'b1;
          end
        end
      end
      StWait: begin
        if (ext_fsync || pending_q) begin
          state_d = StRun;
          consume = 1'b1;
        end else if (!en) begin
          state_d = StIdle;
        end
      end
      StRun: begin
        if (frame_end) begin
          if (!en) begin
            state_d = StIdle;
          end else if (SyncOn && !pending_q) begin
            state_d = StWait;
          end else begin
            consume = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Consumption wins over a pulse landing in the same cycle.
    fsync_set = SyncOn && ext_fsync && ((state_q == StRun) || (state_q == StIdle));
    pending_d = consume ? 1'b0 : (fsync_set | pending_q);
    ovf_d     = fsync_set && pending_q && !consume;

    adv     = (state_d == StRun);
    de_d    = adv && (32'(h_cnt_d) < H_ACTIVE) && (32'(v_cnt_d) < V_ACTIVE);
    line_d  = adv && (h_cnt_d == '0);
    frame_d = line_d && (v_cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      de_q      <= 1'b0;
      de_d1_q   <= 1'b0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      de_q      <= de_d;
      de_d1_q   <= de_q;
      line_q    <= line_d;
      frame_q   <= frame_d;
      ovf_q     <= ovf_d;
    end
  end

  assign out_hcnt        = h_cnt;
  assign out_vcnt        = v_cnt;
  assign out_de          = de_q;
  assign out_de_d1       = de_d1_q;
  assign out_line_start  = line_q;
  assign out_frame_start = frame_q;
  assign out_running     = (state_q == StRun);
  assign out_fsync_ovf   = ovf_q;

endmodule

// File: tb/tb_vid_timing_gen.sv
// Directed bench: two small-raster instances (free-run and frame-locked), 16x8 = 128 cycles/frame.
module tb_vid_timing_gen;

  logic       clk;
  logic       rst0, en0, ext0, rst1, en1, ext1;
  logic [3:0] hcnt0, hcnt1;
  logic [2:0] vcnt0, vcnt1;
  logic       de0, de1, ded0, ded1, ls0, ls1, fs0, fs1, run0, run1, ovf0, ovf1;

  int checks   = 0;
  int failures = 0;
  int dc, fc;

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(3),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1), .SYNC_MODE(0)
  ) dut0 (
    .clk(clk), .rst(rst0), .en(en0), .ext_fsync(ext0),
    .out_hcnt(hcnt0), .out_vcnt(vcnt0), .out_de(de0), .out_de_d1(ded0),
    .out_line_start(ls0), .out_frame_start(fs0), .out_running(run0), .out_fsync_ovf(ovf0)
  );

  vid_timing_gen #(
    .H_ACTIVE(8), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(3),
    .V_ACTIVE(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1), .SYNC_MODE(1)
  ) dut1 (
    .clk(clk), .rst(rst1), .en(en1), .ext_fsync(ext1),
    .out_hcnt(hcnt1), .out_vcnt(vcnt1), .out_de(de1), .out_de_d1(ded1),
    .out_line_start(ls1), .out_frame_start(fs1), .out_running(run1), .out_fsync_ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic de_of(input int p);
    return ((p % 16) < 8) && ((p / 16) < 4);
  endfunction

  // Ticks n cycles; raster position after tick k is (start+k) mod 128.
  task automatic run_frame(input int sel, input int n, input int start,
                           output int de_cnt, output int fs_cnt);
    logic prev_de;
    int   p;
    prev_de = de_of(start % 128);
    de_cnt  = 0;
    fs_cnt  = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      p = (start + k) % 128;
      chk($sformatf("d%0d_hcnt@%0d", sel, p), sel ? 32'(hcnt1) : 32'(hcnt0), p % 16);
      chk($sformatf("d%0d_vcnt@%0d", sel, p), sel ? 32'(vcnt1) : 32'(vcnt0), p / 16);
      chk($sformatf("d%0d_de@%0d", sel, p), sel ? 32'(de1) : 32'(de0), 32'(de_of(p)));
      chk($sformatf("d%0d_de_d1@%0d", sel, p), sel ? 32'(ded1) : 32'(ded0), 32'(prev_de));
      chk($sformatf("d%0d_line@%0d", sel, p), sel ? 32'(ls1) : 32'(ls0), 32'((p % 16) == 0));
      chk($sformatf("d%0d_frame@%0d", sel, p), sel ? 32'(fs1) : 32'(fs0), 32'(p == 0));
      chk($sformatf("d%0d_run@%0d", sel, p), sel ? 32'(run1) : 32'(run0), 1);
      if (sel ? de1 : de0) de_cnt++;
      if (sel ? fs1 : fs0) fs_cnt++;
      prev_de = de_of(p);
    end
  endtask

  initial begin
    rst0 = 1'b1; en0 = 1'b0; ext0 = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; ext1 = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_hcnt", 32'(hcnt0), 15);
    chk("rst_vcnt", 32'(vcnt0), 7);
    chk("rst_de", 32'(de0), 0);
    chk("rst_de_d1", 32'(ded0), 0);
    chk("rst_running", 32'(run0), 0);
    chk("rst_frame", 32'(fs0), 0);
    chk("rst_line", 32'(ls0), 0);
    chk("rst_ovf", 32'(ovf0), 0);
    rst0 = 1'b0;
    tick();
    chk("idle_hold_hcnt", 32'(hcnt0), 15);
    chk("idle_running", 32'(run0), 0);

    // Free-run: two full frames back to back, including both counter wraps
    en0 = 1'b1;
    run_frame(0, 128, 127, dc, fc);
    chk("s1_de_count", dc, 32);
    chk("s1_frame_count", fc, 1);
    run_frame(0, 128, 127, dc, fc);
    chk("s2_de_count", dc, 32);
    chk("s2_frame_count", fc, 1);

    // en dropped at vcnt=1: frame completes, then parks
    run_frame(0, 17, 127, dc, fc);
    en0 = 1'b0;
    run_frame(0, 111, 16, dc, fc);
    tick();
    chk("s3_park_hcnt", 32'(hcnt0), 15);
    chk("s3_park_vcnt", 32'(vcnt0), 7);
    chk("s3_running", 32'(run0), 0);
    chk("s3_de", 32'(de0), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s3_idle_frame", 32'(fs0), 0);
      chk("s3_idle_hcnt", 32'(hcnt0), 15);
      chk("s3_idle_running", 32'(run0), 0);
    end

    // rst mid-frame at hcnt=5, vcnt=2
    en0 = 1'b1;
    run_frame(0, 38, 127, dc, fc);
    rst0 = 1'b1;
    tick();
    chk("s6_hcnt", 32'(hcnt0), 15);
    chk("s6_vcnt", 32'(vcnt0), 7);
    chk("s6_de", 32'(de0), 0);
    chk("s6_de_d1", 32'(ded0), 0);
    chk("s6_running", 32'(run0), 0);
    rst0 = 1'b0;
    run_frame(0, 128, 127, dc, fc);
    chk("s6_de_count", dc, 32);
    chk("s6_frame_count", fc, 1);

    // Free-run ignores ext_fsync
    ext0 = 1'b1;
    run_frame(0, 4, 127, dc, fc);
    ext0 = 1'b0;
    chk("s0_ovf", 32'(ovf0), 0);

    // Frame-locked instance: IDLE -> WAIT -> RUN on ext_fsync
    tick();
    rst1 = 1'b0;
    en1  = 1'b1;
    tick();
    chk("s4_wait_running", 32'(run1), 0);
    chk("s4_wait_hcnt", 32'(hcnt1), 15);
    chk("s4_wait_vcnt", 32'(vcnt1), 7);
    ext1 = 1'b1;
    run_frame(1, 1, 127, dc, fc);
    ext1 = 1'b0;
    chk("s4_start_frame", fc, 1);
    run_frame(1, 127, 0, dc, fc);
    tick();
    chk("s4_end_wait_running", 32'(run1), 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("s4_held_hcnt", 32'(hcnt1), 15);
      chk("s4_held_vcnt", 32'(vcnt1), 7);
      chk("s4_held_frame", 32'(fs1), 0);
    end
    ext1 = 1'b1;
    run_frame(1, 1, 127, dc, fc);
    ext1 = 1'b0;

    // Two pulses in one frame: one overflow, then a back-to-back frame
    run_frame(1, 10, 0, dc, fc);
    ext1 = 1'b1;
    run_frame(1, 1, 10, dc, fc);
    ext1 = 1'b0;
    chk("s5_ovf_first", 32'(ovf1), 0);
    run_frame(1, 19, 11, dc, fc);
    ext1 = 1'b1;
    run_frame(1, 1, 30, dc, fc);
    ext1 = 1'b0;
    chk("s5_ovf_second", 32'(ovf1), 1);
    run_frame(1, 1, 31, dc, fc);
    chk("s5_ovf_clear", 32'(ovf1), 0);
    run_frame(1, 96, 32, dc, fc);
    chk("s5_back_to_back", fc, 1);

    // Pending was consumed, so the next frame end waits again
    run_frame(1, 127, 0, dc, fc);
    tick();
    chk("s5_rewait_running", 32'(run1), 0);
    chk("s5_rewait_hcnt", 32'(hcnt1), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
